// File: rtl/load_use_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/JAL redirect and memory-wait freeze
// for a 5-stage in-order core, with saturating stall/redirect event counters.
module load_use_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        fmt_r,
    input  logic        fmt_i,
    input  logic        fmt_s,
    input  logic        fmt_sb,
    input  logic        fmt_u,
    input  logic        fmt_uj,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  pc_sel,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  state
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ST_W  = 2;

    localparam logic [ST_W-1:0]  ST_INIT    = 2'b00;
    localparam logic [ST_W-1:0]  ST_RUN     = 2'b01;
    localparam logic [ST_W-1:0]  ST_MEMWAIT = 2'b10;

    localparam logic [SEL_W-1:0] SEL_PC4    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_BRANCH = 2'b01;
    localparam logic [SEL_W-1:0] SEL_JAL    = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [ST_W-1:0] nextState;
    logic            rs1Used;
    logic            rs2Used;
    logic            loadUse;
    logic            jalInId;
    logic            stallInc;
    logic            flushInc;

    // U-type reads no source registers; the flag only completes the format vector.
    logic            unusedFmtU;
    assign unusedFmtU = fmt_u;

    // Source-usage decode and hazard detection; x0 is never a real dependency.
    assign rs1Used = fmt_r | fmt_i | fmt_s | fmt_sb;
    assign rs2Used = fmt_r | fmt_s | fmt_sb;
    assign loadUse = id_valid & ex_load & (ex_rd != REG_ZERO)
                   & ((rs1Used & (id_rs1 == ex_rd)) | (rs2Used & (id_rs2 == ex_rd)));
    assign jalInId = id_valid & fmt_uj;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; the unused encoding falls back to INIT
    always_comb begin
        nextState = ST_INIT;
        case (state)
            ST_INIT:    nextState = ST_RUN;
            ST_RUN:     nextState = mem_busy ? ST_MEMWAIT : ST_RUN;
            ST_MEMWAIT: nextState = mem_busy ? ST_MEMWAIT : ST_RUN;
            default:    nextState = ST_INIT;
        endcase
    end

    // Mealy outputs; MEMWAIT with memory ready resolves exactly like RUN
    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        pc_sel     = SEL_PC4;
        stallInc   = 1'b0;
        flushInc   = 1'b0;
        case (state)
            ST_RUN, ST_MEMWAIT: begin
                if (mem_busy) begin
                    ifid_flush = 1'b0;
                    idex_flush = 1'b0;
                    stallInc   = 1'b1;
                end else if (br_taken) begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    pc_sel     = SEL_BRANCH;
                    flushInc   = 1'b1;
                end else if (loadUse) begin
                    ifid_flush = 1'b0;
                    stallInc   = 1'b1;
                end else if (jalInId) begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    idex_flush = 1'b0;
                    pc_sel     = SEL_JAL;
                    flushInc   = 1'b1;
                end else begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b0;
                    idex_flush = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallInc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flushInc && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Scoreboard bench for load_use_hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares against the DUT.
module tb_load_use_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        fmt_r, fmt_i, fmt_s, fmt_sb, fmt_u, fmt_uj;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        br_taken;
    logic        mem_busy;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic [1:0]  pc_sel;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  state;

    typedef struct packed {
        logic [3:0]  ctl;     // {pc_we, ifid_we, ifid_flush, idex_flush}
        logic [1:0]  sel;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [1:0]  st;
    } obs_t;

    obs_t  expQ[$];
    string nameQ[$];
    int    checks = 0;
    int    errors = 0;

    load_use_hazard_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .fmt_r      (fmt_r),
        .fmt_i      (fmt_i),
        .fmt_s      (fmt_s),
        .fmt_sb     (fmt_sb),
        .fmt_u      (fmt_u),
        .fmt_uj     (fmt_uj),
        .ex_load    (ex_load),
        .ex_rd      (ex_rd),
        .br_taken   (br_taken),
        .mem_busy   (mem_busy),
        .pc_we      (pc_we),
        .ifid_we    (ifid_we),
        .ifid_flush (ifid_flush),
        .idex_flush (idex_flush),
        .pc_sel     (pc_sel),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected record per checked cycle, sampled mid-cycle
    always @(negedge clk) begin
        obs_t  got;
        obs_t  e;
        string n;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            got.ctl = {pc_we, ifid_we, ifid_flush, idex_flush};
            got.sel = pc_sel;
            got.sc  = stall_cnt;
            got.fc  = flush_cnt;
            got.st  = state;
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got ctl=%b sel=%b sc=%h fc=%h st=%b, expected ctl=%b sel=%b sc=%h fc=%h st=%b",
                         n, got.ctl, got.sel, got.sc, got.fc, got.st,
                         e.ctl, e.sel, e.sc, e.fc, e.st);
            end
        end
    end

    // Drive one cycle of stimulus and queue its expected outputs; fmt = {r,i,s,sb,u,uj}
    task automatic cyc(input string name, input logic r, input logic vld,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [5:0] fmt,
                       input logic ld, input logic [4:0] rd, input logic br, input logic mb,
                       input logic [3:0] ctl, input logic [1:0] sel,
                       input logic [15:0] sc, input logic [15:0] fc, input logic [1:0] st);
        obs_t e;
        rst      = r;
        id_valid = vld;
        id_rs1   = rs1;
        id_rs2   = rs2;
        {fmt_r, fmt_i, fmt_s, fmt_sb, fmt_u, fmt_uj} = fmt;
        ex_load  = ld;
        ex_rd    = rd;
        br_taken = br;
        mem_busy = mb;
        e.ctl = ctl;
        e.sel = sel;
        e.sc  = sc;
        e.fc  = fc;
        e.st  = st;
        expQ.push_back(e);
        nameQ.push_back(name);
        @(posedge clk);
        #1;
    endtask

    localparam logic [5:0] F_NONE = 6'b000000;
    localparam logic [5:0] F_R    = 6'b100000;
    localparam logic [5:0] F_I    = 6'b010000;
    localparam logic [5:0] F_S    = 6'b001000;
    localparam logic [5:0] F_SB   = 6'b000100;
    localparam logic [5:0] F_U    = 6'b000010;
    localparam logic [5:0] F_UJ   = 6'b000001;
    localparam logic [1:0] INIT = 2'b00, RUN = 2'b01, MW = 2'b10;

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        {fmt_r, fmt_i, fmt_s, fmt_sb, fmt_u, fmt_uj} = F_NONE;
        ex_load = 1'b0; ex_rd = '0; br_taken = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;
        //   name             rst vld rs1 rs2 fmt   ld rd br mb  ctl      sel    sc        fc     st
        cyc("reset_held",      1, 0,  0,  0, F_NONE, 0, 0, 0, 0, 4'b0011, 2'b00, 16'd0,   16'd0, INIT);
        cyc("init_cycle",      0, 0,  0,  0, F_NONE, 0, 0, 0, 0, 4'b0011, 2'b00, 16'd0,   16'd0, INIT);
        cyc("run_idle",        0, 0,  0,  0, F_NONE, 0, 0, 0, 0, 4'b1100, 2'b00, 16'd0,   16'd0, RUN);
        cyc("loaduse_r_rs2",   0, 1,  1,  5, F_R,    1, 5, 0, 0, 4'b0001, 2'b00, 16'd0,   16'd0, RUN);
        cyc("bubble_in_ex",    0, 1,  1,  5, F_R,    0, 0, 0, 0, 4'b1100, 2'b00, 16'd1,   16'd0, RUN);
        cyc("rd_x0_nostall",   0, 1,  0,  0, F_R,    1, 0, 0, 0, 4'b1100, 2'b00, 16'd1,   16'd0, RUN);
        cyc("fmt_u_nostall",   0, 1,  5,  5, F_U,    1, 5, 0, 0, 4'b1100, 2'b00, 16'd1,   16'd0, RUN);
        cyc("fmt_i_rs2_unused",0, 1,  7,  5, F_I,    1, 5, 0, 0, 4'b1100, 2'b00, 16'd1,   16'd0, RUN);
        cyc("loaduse_s_rs2",   0, 1,  2,  9, F_S,    1, 9, 0, 0, 4'b0001, 2'b00, 16'd1,   16'd0, RUN);
        cyc("br_over_lu_jal",  0, 1,  3,  3, F_R|F_UJ, 1, 3, 1, 0, 4'b1111, 2'b01, 16'd2, 16'd0, RUN);
        cyc("loaduse_sb_rs1",  0, 1,  4,  8, F_SB,   1, 4, 0, 0, 4'b0001, 2'b00, 16'd2,   16'd1, RUN);
        cyc("jal_redirect",    0, 1,  0,  0, F_UJ,   0, 0, 0, 0, 4'b1110, 2'b10, 16'd3,   16'd1, RUN);
        cyc("jal_invalid",     0, 0,  0,  0, F_UJ,   0, 0, 0, 0, 4'b1100, 2'b00, 16'd3,   16'd2, RUN);
        cyc("mb_br_run",       0, 0,  0,  0, F_NONE, 0, 0, 1, 1, 4'b0000, 2'b00, 16'd3,   16'd2, RUN);
        cyc("mb_br_wait1",     0, 0,  0,  0, F_NONE, 0, 0, 1, 1, 4'b0000, 2'b00, 16'd4,   16'd2, MW);
        cyc("mb_br_wait2",     0, 0,  0,  0, F_NONE, 0, 0, 1, 1, 4'b0000, 2'b00, 16'd5,   16'd2, MW);
        cyc("mb_drop_branch",  0, 0,  0,  0, F_NONE, 0, 0, 1, 0, 4'b1111, 2'b01, 16'd6,   16'd2, MW);
        cyc("back_to_run",     0, 0,  0,  0, F_NONE, 0, 0, 0, 0, 4'b1100, 2'b00, 16'd6,   16'd3, RUN);
        cyc("mb_again",        0, 0,  0,  0, F_NONE, 0, 0, 0, 1, 4'b0000, 2'b00, 16'd6,   16'd3, RUN);
        cyc("mb_drop_loaduse", 0, 1,  6,  0, F_I,    1, 6, 0, 0, 4'b0001, 2'b00, 16'd7,   16'd3, MW);
        cyc("run_after_lu",    0, 0,  0,  0, F_NONE, 0, 0, 0, 0, 4'b1100, 2'b00, 16'd8,   16'd3, RUN);
        cyc("mb_pre_rst",      0, 0,  0,  0, F_NONE, 0, 0, 0, 1, 4'b0000, 2'b00, 16'd8,   16'd3, RUN);
        cyc("mb_wait_pre_rst", 0, 0,  0,  0, F_NONE, 0, 0, 0, 1, 4'b0000, 2'b00, 16'd9,   16'd3, MW);
        cyc("async_rst_mw",    1, 0,  0,  0, F_NONE, 0, 0, 1, 1, 4'b0011, 2'b00, 16'd0,   16'd0, INIT);
        cyc("init_after_rst",  0, 0,  0,  0, F_NONE, 0, 0, 0, 0, 4'b0011, 2'b00, 16'd0,   16'd0, INIT);
        cyc("run_after_rst",   0, 0,  0,  0, F_NONE, 0, 0, 0, 0, 4'b1100, 2'b00, 16'd0,   16'd0, RUN);

        // Long unchecked freeze brings stall_cnt to 16'hFFFE
        mem_busy = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        cyc("sat_fffe",        0, 0,  0,  0, F_NONE, 0, 0, 0, 1, 4'b0000, 2'b00, 16'hFFFE, 16'd0, MW);
        cyc("sat_ffff_1",      0, 0,  0,  0, F_NONE, 0, 0, 0, 1, 4'b0000, 2'b00, 16'hFFFF, 16'd0, MW);
        cyc("sat_ffff_2",      0, 0,  0,  0, F_NONE, 0, 0, 0, 1, 4'b0000, 2'b00, 16'hFFFF, 16'd0, MW);
        cyc("sat_ffff_lu",     0, 1,  3,  0, F_R,    1, 3, 0, 0, 4'b0001, 2'b00, 16'hFFFF, 16'd0, MW);
        cyc("sat_ffff_hold",   0, 0,  0,  0, F_NONE, 0, 0, 0, 0, 4'b1100, 2'b00, 16'hFFFF, 16'd0, RUN);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 4 && expQ.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
